// File: rtl/hdlverifier_axi_slave_mem.sv
// AXI4 slave backed by a byte-lane word RAM; independent write and read FSMs
// share one write port and one read port of the RAM.
module hdlverifier_axi_slave_mem #(
    parameter int ID_WIDTH       = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ID_WIDTH-1:0]         axi4s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi4s_awaddr,
    input  logic [7:0]                  axi4s_awlen,
    input  logic [2:0]                  axi4s_awsize,
    input  logic [1:0]                  axi4s_awburst,
    input  logic                        axi4s_awvalid,
    output logic                        axi4s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi4s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi4s_wstrb,
    input  logic                        axi4s_wlast,
    input  logic                        axi4s_wvalid,
    output logic                        axi4s_wready,
    output logic [ID_WIDTH-1:0]         axi4s_bid,
    output logic [1:0]                  axi4s_bresp,
    output logic                        axi4s_bvalid,
    input  logic                        axi4s_bready,
    input  logic [ID_WIDTH-1:0]         axi4s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi4s_araddr,
    input  logic [7:0]                  axi4s_arlen,
    input  logic [2:0]                  axi4s_arsize,
    input  logic [1:0]                  axi4s_arburst,
    input  logic                        axi4s_arvalid,
    output logic                        axi4s_arready,
    output logic [ID_WIDTH-1:0]         axi4s_rid,
    output logic [AXI_DATA_WIDTH-1:0]   axi4s_rdata,
    output logic [1:0]                  axi4s_rresp,
    output logic                        axi4s_rlast,
    output logic                        axi4s_rvalid,
    input  logic                        axi4s_rready,
    input  logic [2:0]                  axi4s_awprot,
    input  logic [2:0]                  axi4s_arprot,
    input  logic                        axi4s_awlock,
    input  logic [3:0]                  axi4s_awcache,
    input  logic [3:0]                  axi4s_awqos,
    input  logic                        axi4s_arlock,
    input  logic [3:0]                  axi4s_arcache,
    input  logic [3:0]                  axi4s_arqos
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int B      = (AXI_DATA_WIDTH == 64) ? 3 : 2;
    localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;
    localparam logic [2:0] FULL_SIZE = 3'(B);
    localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = MEM_ADDR_WIDTH'(1);

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

    logic unused_inputs;
    assign unused_inputs = ^{axi4s_awprot, axi4s_arprot, axi4s_awlock, axi4s_awcache,
                             axi4s_awqos, axi4s_arlock, axi4s_arcache, axi4s_arqos,
                             axi4s_awaddr, axi4s_araddr};

    // ---------------- write side ----------------
    logic [1:0]                w_state_q, w_state_d;
    logic                      awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]       bid_q;
    logic [1:0]                bresp_q;
    logic [MEM_ADDR_WIDTH-1:0] widx_q;
    logic [7:0]                wlen_q, wbeat_q;
    logic                      wfixed_q, werr_q, wover_q;
    logic                      aw_hs, w_hs, b_hs, aw_err, ram_we;

    assign aw_hs  = axi4s_awvalid & awready_q;
    assign w_hs   = axi4s_wvalid & wready_q;
    assign b_hs   = bvalid_q & axi4s_bready;
    assign aw_err = axi4s_awburst[1] | (axi4s_awsize != FULL_SIZE);
    // Beats past len are swallowed until wlast shows up
    assign ram_we = w_hs & ~werr_q & ~wover_q;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && axi4s_wlast) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
            wover_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
            if (aw_hs) begin
                bid_q    <= axi4s_awid;
                widx_q   <= axi4s_awaddr[MEM_ADDR_WIDTH+B-1:B];
                wlen_q   <= axi4s_awlen;
                wfixed_q <= (axi4s_awburst == 2'b00);
                werr_q   <= aw_err;
                wbeat_q  <= '0;
                wover_q  <= 1'b0;
            end
            if (w_hs) begin
                wbeat_q <= wbeat_q + 8'd1;
                if (!wfixed_q) widx_q <= widx_q + IDX_ONE;
                if (!axi4s_wlast && wbeat_q == wlen_q) wover_q <= 1'b1;
                if (axi4s_wlast)
                    bresp_q <= (werr_q || wover_q || wbeat_q != wlen_q) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- read side ----------------
    logic [1:0]                r_state_q, r_state_d;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]       rid_q;
    logic [1:0]                rresp_q;
    logic [MEM_ADDR_WIDTH-1:0] ridx_q;
    logic [7:0]                rlen_q, rbeat_q;
    logic                      rfixed_q, rerr_q;
    logic                      ar_hs, r_hs, ar_err, ram_re;
    logic [AXI_DATA_WIDTH-1:0] ram_rd;

    assign ar_hs  = axi4s_arvalid & arready_q;
    assign r_hs   = rvalid_q & axi4s_rready;
    assign ar_err = axi4s_arburst[1] | (axi4s_arsize != FULL_SIZE);
    assign ram_re = (r_state_q == R_FETCH);

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
            R_FETCH: r_state_d = R_DATA;
            R_DATA:  if (r_hs) r_state_d = rlast_q ? R_IDLE : R_FETCH;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= 2'b00;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rfixed_q  <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            if (ar_hs) begin
                rid_q    <= axi4s_arid;
                ridx_q   <= axi4s_araddr[MEM_ADDR_WIDTH+B-1:B];
                rlen_q   <= axi4s_arlen;
                rfixed_q <= (axi4s_arburst == 2'b00);
                rerr_q   <= ar_err;
                rresp_q  <= ar_err ? 2'b10 : 2'b00;
                rbeat_q  <= '0;
            end
            if (ram_re) rlast_q <= (rbeat_q == rlen_q);
            if (r_hs) begin
                rbeat_q <= rbeat_q + 8'd1;
                if (!rfixed_q) ridx_q <= ridx_q + IDX_ONE;
                rlast_q <= 1'b0;
            end
        end
    end

    // RAM: one array per byte lane so strobes map to plain lane write enables
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;
        always_ff @(posedge aclk) begin
            if (ram_we && axi4s_wstrb[gi]) mem_q[widx_q] <= axi4s_wdata[gi*8 +: 8];
            if (ram_re) rd_q <= mem_q[ridx_q];
        end
        assign ram_rd[gi*8 +: 8] = rd_q;
    end

    assign axi4s_awready = awready_q;
    assign axi4s_wready  = wready_q;
    assign axi4s_bvalid  = bvalid_q;
    assign axi4s_bid     = bid_q;
    assign axi4s_bresp   = bresp_q;
    assign axi4s_arready = arready_q;
    assign axi4s_rvalid  = rvalid_q;
    assign axi4s_rlast   = rlast_q;
    assign axi4s_rid     = rid_q;
    assign axi4s_rresp   = rresp_q;
    // RAM output register is unreset, so mask it outside a good data beat
    assign axi4s_rdata   = (rvalid_q && !rerr_q) ? ram_rd : '0;

endmodule

// File: tb/tb_hdlverifier_axi_slave_mem.sv
// Directed table-driven bench for hdlverifier_axi_slave_mem (32-bit data, 256 words).
module tb_hdlverifier_axi_slave_mem;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [0:0]  axi4s_awid, axi4s_arid, axi4s_bid, axi4s_rid;
    logic [31:0] axi4s_awaddr, axi4s_araddr, axi4s_wdata, axi4s_rdata;
    logic [7:0]  axi4s_awlen, axi4s_arlen;
    logic [2:0]  axi4s_awsize, axi4s_arsize, axi4s_awprot, axi4s_arprot;
    logic [1:0]  axi4s_awburst, axi4s_arburst, axi4s_bresp, axi4s_rresp;
    logic        axi4s_awvalid, axi4s_awready, axi4s_wlast, axi4s_wvalid, axi4s_wready;
    logic        axi4s_bvalid, axi4s_bready, axi4s_arvalid, axi4s_arready;
    logic        axi4s_rlast, axi4s_rvalid, axi4s_rready, axi4s_awlock, axi4s_arlock;
    logic [3:0]  axi4s_wstrb, axi4s_awcache, axi4s_awqos, axi4s_arcache, axi4s_arqos;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    hdlverifier_axi_slave_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi4s_awid(axi4s_awid), .axi4s_awaddr(axi4s_awaddr), .axi4s_awlen(axi4s_awlen),
        .axi4s_awsize(axi4s_awsize), .axi4s_awburst(axi4s_awburst),
        .axi4s_awvalid(axi4s_awvalid), .axi4s_awready(axi4s_awready),
        .axi4s_wdata(axi4s_wdata), .axi4s_wstrb(axi4s_wstrb), .axi4s_wlast(axi4s_wlast),
        .axi4s_wvalid(axi4s_wvalid), .axi4s_wready(axi4s_wready),
        .axi4s_bid(axi4s_bid), .axi4s_bresp(axi4s_bresp), .axi4s_bvalid(axi4s_bvalid),
        .axi4s_bready(axi4s_bready),
        .axi4s_arid(axi4s_arid), .axi4s_araddr(axi4s_araddr), .axi4s_arlen(axi4s_arlen),
        .axi4s_arsize(axi4s_arsize), .axi4s_arburst(axi4s_arburst),
        .axi4s_arvalid(axi4s_arvalid), .axi4s_arready(axi4s_arready),
        .axi4s_rid(axi4s_rid), .axi4s_rdata(axi4s_rdata), .axi4s_rresp(axi4s_rresp),
        .axi4s_rlast(axi4s_rlast), .axi4s_rvalid(axi4s_rvalid), .axi4s_rready(axi4s_rready),
        .axi4s_awprot(axi4s_awprot), .axi4s_arprot(axi4s_arprot),
        .axi4s_awlock(axi4s_awlock), .axi4s_awcache(axi4s_awcache),
        .axi4s_awqos(axi4s_awqos), .axi4s_arlock(axi4s_arlock),
        .axi4s_arcache(axi4s_arcache), .axi4s_arqos(axi4s_arqos)
    );

    typedef struct packed {
        bit              wr;
        logic [0:0]      id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [1:0]      burst;
        logic [2:0]      size;
        logic [3:0]      strb;
        logic [2:0]      nb;      // beats driven on W (write only)
        logic [3:0][31:0] d;      // write data or expected read data
        logic [1:0]      resp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [2:0] size,
                                input logic [3:0] strb, input logic [2:0] nb,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.id = 1'b0; v.addr = addr; v.len = len; v.burst = burst;
        v.size = size; v.strb = strb; v.nb = nb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.resp = resp;
        return v;
    endfunction

    task automatic wait_sig(input string name, ref logic sig);
        int cnt = 0;
        while (sig !== 1'b1 && cnt < 50) begin
            @(negedge aclk);
            cnt++;
        end
        chk(name, (cnt < 50), 1);
    endtask

    task automatic do_write(input vec_t v);
        axi4s_awid = v.id; axi4s_awaddr = v.addr; axi4s_awlen = v.len;
        axi4s_awsize = v.size; axi4s_awburst = v.burst; axi4s_awvalid = 1'b1;
        // first W beat offered together with AW; it must not be taken yet
        axi4s_wdata = v.d[0]; axi4s_wstrb = v.strb; axi4s_wlast = (v.nb == 3'd1);
        axi4s_wvalid = 1'b1;
        chk("wready_idle", axi4s_wready, 0);
        wait_sig("aw_wait", axi4s_awready);
        @(negedge aclk);
        axi4s_awvalid = 1'b0;
        chk("wready_after_aw", axi4s_wready, 1);
        chk("awready_busy", axi4s_awready, 0);
        for (int b = 0; b < int'(v.nb); b++) begin
            axi4s_wdata = v.d[b]; axi4s_wlast = (b == int'(v.nb) - 1);
            wait_sig("w_wait", axi4s_wready);
            @(negedge aclk);
        end
        axi4s_wvalid = 1'b0; axi4s_wlast = 1'b0;
        chk("bvalid", axi4s_bvalid, 1);
        chk("bresp", axi4s_bresp, v.resp);
        chk("bid", axi4s_bid, v.id);
        axi4s_bready = 1'b1;
        @(negedge aclk);
        axi4s_bready = 1'b0;
        chk("bvalid_drop", axi4s_bvalid, 0);
        chk("awready_back", axi4s_awready, 1);
        $display("WR addr=%08h len=%0d burst=%0d size=%0d strb=%h beats=%0d bresp=%0d",
                 v.addr, v.len, v.burst, v.size, v.strb, v.nb, axi4s_bresp);
    endtask

    task automatic do_read(input vec_t v);
        int cnt;
        axi4s_arid = v.id; axi4s_araddr = v.addr; axi4s_arlen = v.len;
        axi4s_arsize = v.size; axi4s_arburst = v.burst; axi4s_arvalid = 1'b1;
        wait_sig("ar_wait", axi4s_arready);
        @(negedge aclk);
        axi4s_arvalid = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            cnt = 0;
            while (axi4s_rvalid !== 1'b1 && cnt < 50) begin
                @(negedge aclk);
                cnt++;
            end
            chk("r_latency", cnt, 1);
            chk("rdata", axi4s_rdata, v.d[b]);
            chk("rresp", axi4s_rresp, v.resp);
            chk("rlast", axi4s_rlast, (b == int'(v.len)));
            chk("rid", axi4s_rid, v.id);
            axi4s_rready = 1'b1;
            @(negedge aclk);
            axi4s_rready = 1'b0;
        end
        chk("arready_back", axi4s_arready, 1);
        chk("rvalid_drop", axi4s_rvalid, 0);
        $display("RD addr=%08h len=%0d burst=%0d size=%0d rresp=%0d",
                 v.addr, v.len, v.burst, v.size, v.resp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   beat, cyc;
        bit   stalled;
        logic [31:0] held_d;
        logic held_l;
        vec_t v;

        aresetn = 1'b0;
        axi4s_awid = '0; axi4s_awaddr = '0; axi4s_awlen = '0; axi4s_awsize = '0;
        axi4s_awburst = '0; axi4s_awvalid = 1'b0; axi4s_wdata = '0; axi4s_wstrb = '0;
        axi4s_wlast = 1'b0; axi4s_wvalid = 1'b0; axi4s_bready = 1'b0;
        axi4s_arid = '0; axi4s_araddr = '0; axi4s_arlen = '0; axi4s_arsize = '0;
        axi4s_arburst = '0; axi4s_arvalid = 1'b0; axi4s_rready = 1'b0;
        axi4s_awprot = '0; axi4s_arprot = '0; axi4s_awlock = 1'b0; axi4s_arlock = 1'b0;
        axi4s_awcache = '0; axi4s_awqos = '0; axi4s_arcache = '0; axi4s_arqos = '0;

        //            wr    addr      len burst size strb nb  d0..d3                                              resp
        vecs[0]  = mk(1, 32'h10,    3, 2'b01, 2, 4'hF, 4, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
        vecs[1]  = mk(0, 32'h10,    3, 2'b01, 2, 4'hF, 0, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
        vecs[2]  = mk(1, 32'h40,    0, 2'b01, 2, 4'hF, 1, 32'hAABBCCDD, 0, 0, 0, 2'b00);
        vecs[3]  = mk(1, 32'h40,    0, 2'b01, 2, 4'h5, 1, 32'h00000000, 0, 0, 0, 2'b00);
        vecs[4]  = mk(0, 32'h40,    0, 2'b01, 2, 4'hF, 0, 32'hAA00CC00, 0, 0, 0, 2'b00);
        vecs[5]  = mk(1, 32'h20,    3, 2'b00, 2, 4'hF, 4, 32'h1, 32'h2, 32'h3, 32'h4, 2'b00);
        vecs[6]  = mk(0, 32'h20,    0, 2'b01, 2, 4'hF, 0, 32'h4, 0, 0, 0, 2'b00);
        vecs[7]  = mk(1, 32'h3FC,   1, 2'b01, 2, 4'hF, 2, 32'hC0FFEE01, 32'hC0FFEE02, 0, 0, 2'b00);
        vecs[8]  = mk(0, 32'h3FC,   1, 2'b01, 2, 4'hF, 0, 32'hC0FFEE01, 32'hC0FFEE02, 0, 0, 2'b00);
        vecs[9]  = mk(0, 32'h0,     0, 2'b01, 2, 4'hF, 0, 32'hC0FFEE02, 0, 0, 0, 2'b00);
        vecs[10] = mk(1, 32'h10,    1, 2'b10, 2, 4'hF, 2, 32'hDEAD0001, 32'hDEAD0002, 0, 0, 2'b10);
        vecs[11] = mk(1, 32'h14,    0, 2'b01, 1, 4'hF, 1, 32'hDEAD0003, 0, 0, 0, 2'b10);
        vecs[12] = mk(0, 32'h10,    3, 2'b01, 2, 4'hF, 0, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
        vecs[13] = mk(0, 32'h10,    3, 2'b10, 2, 4'hF, 0, 0, 0, 0, 0, 2'b10);
        vecs[14] = mk(0, 32'h10,    0, 2'b01, 1, 4'hF, 0, 0, 0, 0, 0, 2'b10);
        vecs[15] = mk(0, 32'h10410, 0, 2'b01, 2, 4'hF, 0, 32'h11, 0, 0, 0, 2'b00);
        vecs[16] = mk(0, 32'h1C,    2, 2'b00, 2, 4'hF, 0, 32'h44, 32'h44, 32'h44, 0, 2'b00);
        vecs[17] = mk(1, 32'h60,    0, 2'b01, 2, 4'hF, 2, 32'h55, 32'h66, 0, 0, 2'b10);
        vecs[18] = mk(0, 32'h60,    0, 2'b01, 2, 4'hF, 0, 32'h55, 0, 0, 0, 2'b00);
        vecs[19] = mk(1, 32'h70,    3, 2'b01, 2, 4'hF, 2, 32'h77, 32'h88, 0, 0, 2'b10);
        vecs[20] = mk(0, 32'h70,    1, 2'b11, 2, 4'hF, 0, 0, 0, 0, 0, 2'b10);

        // reset values
        repeat (3) @(negedge aclk);
        chk("rst_awready", axi4s_awready, 0);
        chk("rst_arready", axi4s_arready, 0);
        chk("rst_wready", axi4s_wready, 0);
        chk("rst_bvalid", axi4s_bvalid, 0);
        chk("rst_rvalid", axi4s_rvalid, 0);
        chk("rst_rlast", axi4s_rlast, 0);
        chk("rst_bresp", axi4s_bresp, 0);
        chk("rst_rresp", axi4s_rresp, 0);
        chk("rst_rdata", axi4s_rdata, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awready", axi4s_awready, 1);
        chk("rel_arready", axi4s_arready, 1);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            v.id = 1'(i);
            if (v.wr) do_write(v);
            else      do_read(v);
        end

        // write len 7 with B response held off for 5 cycles
        axi4s_awid = 1'b1; axi4s_awaddr = 32'h80; axi4s_awlen = 8'd7;
        axi4s_awsize = 3'd2; axi4s_awburst = 2'b01; axi4s_awvalid = 1'b1;
        wait_sig("bp_aw_wait", axi4s_awready);
        @(negedge aclk);
        axi4s_awvalid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            axi4s_wdata = 32'h1000 + 32'(b); axi4s_wstrb = 4'hF;
            axi4s_wlast = (b == 7); axi4s_wvalid = 1'b1;
            wait_sig("bp_w_wait", axi4s_wready);
            @(negedge aclk);
        end
        axi4s_wvalid = 1'b0; axi4s_wlast = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid_hold", axi4s_bvalid, 1);
            chk("bp_awready_low", axi4s_awready, 0);
            @(negedge aclk);
        end
        chk("bp_bresp", axi4s_bresp, 0);
        chk("bp_bid", axi4s_bid, 1);
        axi4s_bready = 1'b1;
        @(negedge aclk);
        axi4s_bready = 1'b0;
        chk("bp_awready_back", axi4s_awready, 1);
        $display("WR addr=00000080 len=7 burst=1 bready held low 5 cycles");

        // read len 7, stalling every even beat for one cycle
        axi4s_arid = 1'b1; axi4s_araddr = 32'h80; axi4s_arlen = 8'd7;
        axi4s_arsize = 3'd2; axi4s_arburst = 2'b01; axi4s_arvalid = 1'b1;
        wait_sig("bp_ar_wait", axi4s_arready);
        @(negedge aclk);
        axi4s_arvalid = 1'b0;
        beat = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        while (beat < 8 && cyc < 100) begin
            if (stalled) begin
                chk("bp_stall_valid", axi4s_rvalid, 1);
                chk("bp_stall_data", axi4s_rdata, held_d);
                chk("bp_stall_last", axi4s_rlast, held_l);
            end
            if (axi4s_rvalid) begin
                if (!stalled && beat[0] == 1'b0) begin
                    stalled = 1'b1; held_d = axi4s_rdata; held_l = axi4s_rlast;
                    axi4s_rready = 1'b0;
                end else begin
                    chk("bp_rdata", axi4s_rdata, 32'h1000 + 32'(beat));
                    chk("bp_rlast", axi4s_rlast, (beat == 7));
                    stalled = 1'b0;
                    axi4s_rready = 1'b1;
                    beat++;
                end
            end else begin
                axi4s_rready = 1'b0;
            end
            @(negedge aclk);
            cyc++;
        end
        axi4s_rready = 1'b0;
        chk("bp_beats", beat, 8);
        chk("bp_arready_back", axi4s_arready, 1);
        chk("bp_rvalid_drop", axi4s_rvalid, 0);
        $display("RD addr=00000080 len=7 with rready stalls, beats=%0d", beat);

        // reset pulse in the middle of a read burst
        axi4s_arid = 1'b0; axi4s_araddr = 32'h80; axi4s_arlen = 8'd7;
        axi4s_arsize = 3'd2; axi4s_arburst = 2'b01; axi4s_arvalid = 1'b1;
        wait_sig("mr_ar_wait", axi4s_arready);
        @(negedge aclk);
        axi4s_arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wait_sig("mr_r_wait", axi4s_rvalid);
            axi4s_rready = 1'b1;
            @(negedge aclk);
            axi4s_rready = 1'b0;
        end
        wait_sig("mr_r_wait", axi4s_rvalid);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mr_rvalid", axi4s_rvalid, 0);
        chk("mr_arready", axi4s_arready, 0);
        chk("mr_rlast", axi4s_rlast, 0);
        chk("mr_rdata", axi4s_rdata, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mr_arready_rel", axi4s_arready, 1);
        chk("mr_awready_rel", axi4s_awready, 1);
        $display("RST pulse during read burst at beat 2");
        v = mk(0, 32'h80, 1, 2'b01, 2, 4'hF, 0, 32'h1000, 32'h1001, 0, 0, 2'b00);
        do_read(v);
        v = mk(0, 32'h10, 3, 2'b01, 2, 4'hF, 0, 32'h11, 32'h22, 32'h33, 32'h44, 2'b00);
        do_read(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
